// File: rtl/ysyx_220066_dmem_resp_if.sv
// Load/store port between the core's M stage and the data-memory responder.
// The master (core) drives requests; the slave (memory) drives responses.
interface ysyx_220066_dmem_resp_if;
  logic        MemRd;
  logic        MemWr;
  logic [2:0]  MemOp;
  logic [63:0] addr;
  logic [63:0] data_Wr;
  logic [63:0] data_Rd;
  logic        data_Rd_valid;
  logic        data_Rd_error;
  logic        wr_err;

  modport master (
    output MemRd, MemWr, MemOp, addr, data_Wr,
    input  data_Rd, data_Rd_valid, data_Rd_error, wr_err
  );

  modport slave (
    input  MemRd, MemWr, MemOp, addr, data_Wr,
    output data_Rd, data_Rd_valid, data_Rd_error, wr_err
  );
endinterface

// File: rtl/ysyx_220066_dmem_resp.sv
// Data-memory responder for the M-stage load/store port.
// Holds a 2^AW x 64-bit SRAM. Loads answer RD_LAT cycles after the request is
// first seen in IDLE, with a single-cycle data_Rd_valid pulse. Stores commit
// at the sampling edge; rejected stores raise a one-cycle wr_err pulse.
module ysyx_220066_dmem_resp #(
  parameter logic [63:0] BASE   = 64'h8000_0000,
  parameter int          AW     = 16,
  parameter int          RD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_220066_dmem_resp_if.slave        bus
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [63:0] LIMIT = BASE + (64'd8 << AW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Doubleword storage; byte lanes are written individually.
  logic [63:0] mem [DEPTH];

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [63:0] addr_reg, addr_next;
  logic [2:0]  op_reg, op_next;
  logic        err_reg, err_next;
  logic [63:0] rd_data_reg, rd_data_next;
  logic        rd_err_reg, rd_err_next;
  logic        rd_valid_reg, rd_valid_next;
  logic        wr_err_reg, wr_err_next;
  logic        respond;

  // Window, alignment and opcode check shared by loads and stores.
  function automatic logic access_bad(input logic [63:0] a, input logic [2:0] op);
    logic oow;
    logic mis;
    oow = (a < BASE) || (a >= LIMIT);
    case (op[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = |a[1:0];
      2'b11:   mis = |a[2:0];
      default: mis = 1'b0;
    endcase
    return oow || mis || (op == 3'b111);
  endfunction

  // Pick the addressed lane out of a doubleword and extend it to 64 bits.
  function automatic logic [63:0] load_extract(input logic [63:0] word,
                                               input logic [2:0]  op,
                                               input logic [2:0]  lane);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {lane, 3'b000};
    case (op)
      3'b000:  res = {{56{sh[7]}},  sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = sh;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------- load side
  logic        ld_err;
  logic [63:0] sel_addr;
  logic [2:0]  sel_op;
  logic        sel_err;
  logic [AW-1:0] sel_idx;
  logic [63:0] rd_word;

  assign ld_err = access_bad(bus.addr, bus.MemOp);

  // With RD_LAT=1 the response is formed straight from IDLE, so the read
  // source follows the live request there and the latched one in WAIT.
  assign sel_addr = (state_reg == IDLE) ? bus.addr  : addr_reg;
  assign sel_op   = (state_reg == IDLE) ? bus.MemOp : op_reg;
  assign sel_err  = (state_reg == IDLE) ? ld_err    : err_reg;
  assign sel_idx  = AW'((sel_addr - BASE) >> 3);
  assign rd_word  = mem[sel_idx];

  // --------------------------------------------------------------- store side
  logic          st_err;
  logic          wr_fire;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_lo;
  logic [3:0]    wr_hi;
  logic [7:0]    wr_be;
  logic [63:0]   wr_data_sh;

  assign st_err     = access_bad(bus.addr, bus.MemOp) || bus.MemOp[2];
  assign wr_fire    = bus.MemWr && !bus.MemRd && (state_reg == IDLE) && !st_err;
  assign wr_idx     = AW'((bus.addr - BASE) >> 3);
  assign wr_lo      = {1'b0, bus.addr[2:0]};
  assign wr_hi      = wr_lo + (4'd1 << bus.MemOp[1:0]);
  assign wr_data_sh = bus.data_Wr << {bus.addr[2:0], 3'b000};

  // Byte lane gi is enabled when it falls inside [lane, lane + size).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_be
      assign wr_be[gi] = (4'(gi) >= wr_lo) && (4'(gi) < wr_hi);
    end
  endgenerate

  // Byte-masked store into the addressed doubleword.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data_sh[b*8 +: 8];
        end
      end
    end
  end

  // Any store that is not committed is reported back the next cycle.
  assign wr_err_next = bus.MemWr && !wr_fire;

  // Next-state and response formation for the load FSM. cnt holds the number
  // of WAIT cycles still to run, so the response lands exactly RD_LAT cycles
  // after the request is first seen in IDLE.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    op_next       = op_reg;
    err_next      = err_reg;
    rd_data_next  = rd_data_reg;
    rd_err_next   = rd_err_reg;
    rd_valid_next = 1'b0;
    respond       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.MemRd) begin
          addr_next = bus.addr;
          op_next   = bus.MemOp;
          err_next  = ld_err;
          cnt_next  = 4'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            state_next = RESP;
            respond    = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.MemRd) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          respond    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (respond) begin
      rd_valid_next = 1'b1;
      rd_err_next   = sel_err;
      rd_data_next  = sel_err ? 64'd0 : load_extract(rd_word, sel_op, sel_addr[2:0]);
    end
  end

  // State and response registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= 64'd0;
      op_reg       <= 3'd0;
      err_reg      <= 1'b0;
      rd_data_reg  <= 64'd0;
      rd_err_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      wr_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      op_reg       <= op_next;
      err_reg      <= err_next;
      rd_data_reg  <= rd_data_next;
      rd_err_reg   <= rd_err_next;
      rd_valid_reg <= rd_valid_next;
      wr_err_reg   <= wr_err_next;
    end
  end

  assign bus.data_Rd       = rd_data_reg;
  assign bus.data_Rd_valid = rd_valid_reg;
  assign bus.data_Rd_error = rd_err_reg;
  assign bus.wr_err        = wr_err_reg;

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Directed bench for ysyx_220066_dmem_resp: a vector table on an RD_LAT=2
// instance plus hand-written multi-cycle sequences, and back-to-back load
// timing on RD_LAT=1 and RD_LAT=15 instances.
module tb_ysyx_220066_dmem_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] t_addr;
  logic [2:0]  t_op;
  logic [63:0] t_wdata;
  logic        rd_req [3];
  logic        wr_req [3];

  logic [63:0] o_data  [3];
  logic        o_valid [3];
  logic        o_err   [3];
  logic        o_wrerr [3];

  ysyx_220066_dmem_resp_if bus0 ();
  ysyx_220066_dmem_resp_if bus1 ();
  ysyx_220066_dmem_resp_if bus2 ();

  assign bus0.MemRd = rd_req[0];
  assign bus0.MemWr = wr_req[0];
  assign bus0.MemOp = t_op;
  assign bus0.addr = t_addr;
  assign bus0.data_Wr = t_wdata;
  assign bus1.MemRd = rd_req[1];
  assign bus1.MemWr = wr_req[1];
  assign bus1.MemOp = t_op;
  assign bus1.addr = t_addr;
  assign bus1.data_Wr = t_wdata;
  assign bus2.MemRd = rd_req[2];
  assign bus2.MemWr = wr_req[2];
  assign bus2.MemOp = t_op;
  assign bus2.addr = t_addr;
  assign bus2.data_Wr = t_wdata;

  assign o_data[0] = bus0.data_Rd;
  assign o_valid[0] = bus0.data_Rd_valid;
  assign o_err[0] = bus0.data_Rd_error;
  assign o_wrerr[0] = bus0.wr_err;
  assign o_data[1] = bus1.data_Rd;
  assign o_valid[1] = bus1.data_Rd_valid;
  assign o_err[1] = bus1.data_Rd_error;
  assign o_wrerr[1] = bus1.wr_err;
  assign o_data[2] = bus2.data_Rd;
  assign o_valid[2] = bus2.data_Rd_valid;
  assign o_err[2] = bus2.data_Rd_error;
  assign o_wrerr[2] = bus2.wr_err;

  ysyx_220066_dmem_resp #(.RD_LAT(2))  u_lat2  (.clk(clk), .rst(rst), .bus(bus0));
  ysyx_220066_dmem_resp #(.RD_LAT(1))  u_lat1  (.clk(clk), .rst(rst), .bus(bus1));
  ysyx_220066_dmem_resp #(.RD_LAT(15)) u_lat15 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    string       name;
    logic        st;
    logic [63:0] a;
    logic [2:0]  op;
    logic [63:0] wd;
    logic [63:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vtab [$];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int k, input logic [63:0] a, input logic [2:0] op,
                          input logic [63:0] d, output logic werr);
    t_addr = a;
    t_op = op;
    t_wdata = d;
    wr_req[k] = 1'b1;
    step();
    wr_req[k] = 1'b0;
    werr = o_wrerr[k];
  endtask

  // Issue a load, wait (bounded) for valid, then spend one cycle in IDLE.
  task automatic do_load(input int k, input logic [63:0] a, input logic [2:0] op,
                         output logic [63:0] d, output logic e, output int lat);
    logic got;
    t_addr = a;
    t_op = op;
    rd_req[k] = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      lat++;
      got = o_valid[k];
    end
    d = o_data[k];
    e = o_err[k];
    rd_req[k] = 1'b0;
    step();
  endtask

  // Three loads held back to back; the first answers after L cycles, each
  // following one L+1 cycles after the previous valid pulse.
  task automatic b2b(input int k, input int L);
    logic [63:0] addrs [3];
    logic [63:0] exps  [3];
    logic        got;
    logic        seen;
    int          lat;
    addrs[0] = 64'h8000_0010;
    addrs[1] = 64'h8000_0018;
    addrs[2] = 64'h8000_0020;
    exps[0] = 64'hA5A5_5A5A_0F0F_F0F0;
    exps[1] = 64'h0123_4567_89AB_CDEF;
    exps[2] = 64'hFEDC_BA98_7654_3210;
    t_op = 3'b011;
    rd_req[k] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      t_addr = addrs[n];
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        step();
        lat++;
        got = o_valid[k];
      end
      chkint($sformatf("b2b_lat%0d_n%0d_latency", L, n), lat, (n == 0) ? L : L + 1);
      chk64($sformatf("b2b_lat%0d_n%0d_data", L, n), o_data[k], exps[n]);
      $display("b2b RD_LAT=%0d load %0d: latency %0d data %h", L, n, lat, o_data[k]);
    end
    rd_req[k] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < L + 3; i++) begin
      step();
      seen = seen | o_valid[k];
    end
    chk1($sformatf("b2b_lat%0d_no_extra", L), seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic        e;
    logic        werr;
    logic        seen;
    int          lat;

    t_addr = 64'd0;
    t_op = 3'd0;
    t_wdata = 64'd0;
    for (int k = 0; k < 3; k++) begin
      rd_req[k] = 1'b0;
      wr_req[k] = 1'b0;
    end

    vtab.push_back('{"sd_base",   1'b1, 64'h8000_0000, 3'b011, 64'h1122_3344_5566_7788, 64'd0, 1'b0});
    vtab.push_back('{"ld_base",   1'b0, 64'h8000_0000, 3'b011, 64'd0, 64'h1122_3344_5566_7788, 1'b0});
    vtab.push_back('{"lb_7",      1'b0, 64'h8000_0007, 3'b000, 64'd0, 64'h0000_0000_0000_0011, 1'b0});
    vtab.push_back('{"lw_4",      1'b0, 64'h8000_0004, 3'b010, 64'd0, 64'h0000_0000_1122_3344, 1'b0});
    vtab.push_back('{"lbu_0",     1'b0, 64'h8000_0000, 3'b100, 64'd0, 64'h0000_0000_0000_0088, 1'b0});
    vtab.push_back('{"sb_1",      1'b1, 64'h8000_0001, 3'b000, 64'h1234_5678_9ABC_DE80, 64'd0, 1'b0});
    vtab.push_back('{"lb_1",      1'b0, 64'h8000_0001, 3'b000, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
    vtab.push_back('{"lh_mis",    1'b0, 64'h8000_0003, 3'b001, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"sw_mis",    1'b1, 64'h8000_0002, 3'b010, 64'hAAAA_AAAA, 64'd0, 1'b1});
    vtab.push_back('{"ld_after",  1'b0, 64'h8000_0000, 3'b011, 64'd0, 64'h1122_3344_5566_8088, 1'b0});
    vtab.push_back('{"ld_below",  1'b0, 64'h7FFF_FFF8, 3'b011, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"ld_above",  1'b0, 64'h8008_0000, 3'b011, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"ld_op7",    1'b0, 64'h8000_0000, 3'b111, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"lhu_6",     1'b0, 64'h8000_0006, 3'b101, 64'd0, 64'h0000_0000_0000_1122, 1'b0});
    vtab.push_back('{"sw_8",      1'b1, 64'h8000_0008, 3'b010, 64'hFFFF_FFFF_89AB_CDEF, 64'd0, 1'b0});
    vtab.push_back('{"lw_8",      1'b0, 64'h8000_0008, 3'b010, 64'd0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0});
    vtab.push_back('{"lwu_8",     1'b0, 64'h8000_0008, 3'b110, 64'd0, 64'h0000_0000_89AB_CDEF, 1'b0});
    vtab.push_back('{"lh_a",      1'b0, 64'h8000_000A, 3'b001, 64'd0, 64'hFFFF_FFFF_FFFF_89AB, 1'b0});
    vtab.push_back('{"lhu_a",     1'b0, 64'h8000_000A, 3'b101, 64'd0, 64'h0000_0000_0000_89AB, 1'b0});
    vtab.push_back('{"sbu_bad",   1'b1, 64'h8000_0000, 3'b100, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"sd_top",    1'b1, 64'h8007_FFF8, 3'b011, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0});
    vtab.push_back('{"ld_top",    1'b0, 64'h8007_FFF8, 3'b011, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0});
    vtab.push_back('{"sd_above",  1'b1, 64'h8008_0000, 3'b011, 64'd0, 64'd0, 1'b1});
    vtab.push_back('{"ld_base2",  1'b0, 64'h8000_0000, 3'b011, 64'd0, 64'h1122_3344_5566_8088, 1'b0});

    // Reset state.
    rst = 1'b1;
    step();
    step();
    chk64("reset_data", o_data[0], 64'd0);
    chk1("reset_valid", o_valid[0], 1'b0);
    chk1("reset_error", o_err[0], 1'b0);
    chk1("reset_wr_err", o_wrerr[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Table of single transactions on the RD_LAT=2 instance.
    foreach (vtab[i]) begin
      if (vtab[i].st) begin
        do_store(0, vtab[i].a, vtab[i].op, vtab[i].wd, werr);
        chk1({vtab[i].name, "_wr_err"}, werr, vtab[i].exp_e);
        $display("store %s @%h op %0d: wr_err %b", vtab[i].name, vtab[i].a, vtab[i].op, werr);
      end else begin
        do_load(0, vtab[i].a, vtab[i].op, d, e, lat);
        chk64({vtab[i].name, "_data"}, d, vtab[i].exp_d);
        chk1({vtab[i].name, "_error"}, e, vtab[i].exp_e);
        chkint({vtab[i].name, "_latency"}, lat, 2);
        $display("load %s @%h op %0d: data %h err %b latency %0d", vtab[i].name, vtab[i].a, vtab[i].op, d, e, lat);
      end
    end

    // Store and load together in IDLE: store dropped, load served.
    t_addr = 64'h8000_0000;
    t_op = 3'b011;
    t_wdata = 64'd0;
    wr_req[0] = 1'b1;
    rd_req[0] = 1'b1;
    step();
    chk1("both_wr_err", o_wrerr[0], 1'b1);
    chk1("both_wait_valid", o_valid[0], 1'b0);
    wr_req[0] = 1'b0;
    step();
    chk1("both_valid", o_valid[0], 1'b1);
    chk64("both_data", o_data[0], 64'h1122_3344_5566_8088);
    $display("store+load together: wr_err seen, load data %h", o_data[0]);
    rd_req[0] = 1'b0;
    step();

    // Store during WAIT is dropped.
    rd_req[0] = 1'b1;
    step();
    chk1("wait_store_valid0", o_valid[0], 1'b0);
    wr_req[0] = 1'b1;
    step();
    chk1("wait_store_valid1", o_valid[0], 1'b1);
    chk1("wait_store_wr_err", o_wrerr[0], 1'b1);
    chk64("wait_store_data", o_data[0], 64'h1122_3344_5566_8088);
    $display("store during WAIT: wr_err %b data %h", o_wrerr[0], o_data[0]);
    wr_req[0] = 1'b0;
    rd_req[0] = 1'b0;
    step();
    do_load(0, 64'h8000_0000, 3'b011, d, e, lat);
    chk64("wait_store_mem_kept", d, 64'h1122_3344_5566_8088);

    // Load aborted in WAIT produces no response.
    t_addr = 64'h8000_0008;
    t_op = 3'b011;
    rd_req[0] = 1'b1;
    step();
    rd_req[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | o_valid[0];
    end
    chk1("abort_no_valid", seen, 1'b0);
    $display("abort in WAIT: valid seen %b", seen);

    // Back-to-back timing on RD_LAT=1 and RD_LAT=15.
    for (int k = 1; k < 3; k++) begin
      do_store(k, 64'h8000_0010, 3'b011, 64'hA5A5_5A5A_0F0F_F0F0, werr);
      do_store(k, 64'h8000_0018, 3'b011, 64'h0123_4567_89AB_CDEF, werr);
      do_store(k, 64'h8000_0020, 3'b011, 64'hFEDC_BA98_7654_3210, werr);
      chk1($sformatf("b2b_setup%0d_wr_err", k), werr, 1'b0);
    end
    b2b(1, 1);
    b2b(2, 15);

    // Reset in the middle of a load.
    do_load(0, 64'h8000_0000, 3'b011, d, e, lat);
    t_addr = 64'h8000_0008;
    t_op = 3'b011;
    rd_req[0] = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk64("midrst_data", o_data[0], 64'd0);
    chk1("midrst_valid", o_valid[0], 1'b0);
    chk1("midrst_error", o_err[0], 1'b0);
    chk1("midrst_wr_err", o_wrerr[0], 1'b0);
    $display("reset mid-load: data %h valid %b", o_data[0], o_valid[0]);
    rd_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | o_valid[0];
    end
    chk1("midrst_no_resp", seen, 1'b0);
    do_load(0, 64'h8000_0000, 3'b011, d, e, lat);
    chk64("postrst_data", d, 64'h1122_3344_5566_8088);
    chk1("postrst_error", e, 1'b0);
    chkint("postrst_latency", lat, 2);
    $display("load after reset: data %h err %b latency %0d", d, e, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
